// File: rtl/counter_cmd_scheduler.sv
// counter_cmd_scheduler: edge-detects up/down requests from N requesters and serves them round-robin as count/de_count pulses.
// Latency: 2 clocks from request rise to pulse; at most one pulse every GAP+2 clocks.
// Backpressure: none upstream; a command waits in its pending flag, and repeat edges merge into it. Build option: COUNTER_SCHED_WRAP_EN.
module counter_cmd_scheduler #(
    parameter int N   = 2,
    parameter int GAP = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req_inc,
    input  logic [N-1:0] req_dec,
    input  logic [3:0]   counter_value,
    output logic         count,
    output logic         de_count,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic         drop
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [PW-1:0]   sel, sel_nxt;
    logic            sel_inc, sel_inc_nxt;
    logic [GW-1:0]   gap_cnt, gap_nxt;
    logic [N-1:0]    req_inc_q, req_dec_q;
    logic [N-1:0]    pend_inc, pend_dec;
    logic [N-1:0]    clr_inc, clr_dec;
    logic            count_nxt, de_count_nxt, drop_nxt;
    logic [N-1:0]    grant_nxt;
    logic            found;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   cand;
    int              idx;
    logic            at_max, at_min;

`ifdef COUNTER_SCHED_WRAP_EN
    // Wrapping build: the counter is allowed to roll over, so nothing is ever rejected.
    logic unused_counter_value;
    assign unused_counter_value = ^counter_value;
    assign at_max = 1'b0;
    assign at_min = 1'b0;
`else
    assign at_max = (counter_value == 4'hF);
    assign at_min = (counter_value == 4'h0);
`endif

    // Round-robin successor of a requester index.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (int'(p) >= N - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Next-state and next-output logic: pick in IDLE, retire in ISSUE, settle in WAIT.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        sel_nxt      = sel;
        sel_inc_nxt  = sel_inc;
        gap_nxt      = gap_cnt;
        clr_inc      = '0;
        clr_dec      = '0;
        count_nxt    = 1'b0;
        de_count_nxt = 1'b0;
        drop_nxt     = 1'b0;
        grant_nxt    = '0;
        found        = 1'b0;
        pick         = '0;
        cand         = '0;
        idx          = 0;

        // First pending requester at or after ptr, wrapping around.
        for (int j = 0; j < N; j++) begin
            idx = int'(ptr) + j;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = PW'(idx);
            if (!found && (pend_inc[cand] || pend_dec[cand])) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        case (state)
            S_IDLE: begin
                if (found) begin
                    if (pend_inc[pick] && pend_dec[pick]) begin
                        // Opposing commands cancel; nothing is issued or reported.
                        clr_inc[pick] = 1'b1;
                        clr_dec[pick] = 1'b1;
                        ptr_nxt       = next_ptr(pick);
                    end else begin
                        sel_nxt         = pick;
                        sel_inc_nxt     = pend_inc[pick];
                        grant_nxt[pick] = 1'b1;
                        state_nxt       = S_ISSUE;
                        if (pend_inc[pick]) begin
                            if (at_max) drop_nxt = 1'b1;
                            else        count_nxt = 1'b1;
                        end else begin
                            if (at_min) drop_nxt = 1'b1;
                            else        de_count_nxt = 1'b1;
                        end
                    end
                end
            end
            S_ISSUE: begin
                // A fresh edge arriving on this same clock re-sets the flag below.
                if (sel_inc) clr_inc[sel] = 1'b1;
                else         clr_dec[sel] = 1'b1;
                ptr_nxt = next_ptr(sel);
                if (drop) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_WAIT;
                    gap_nxt   = '0;
                end
            end
            S_WAIT: begin
                if (gap_cnt == GW'(GAP - 1)) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, pointer, edge history, pending flags and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            sel       <= '0;
            sel_inc   <= 1'b0;
            gap_cnt   <= '0;
            req_inc_q <= '1;
            req_dec_q <= '1;
            pend_inc  <= '0;
            pend_dec  <= '0;
            count     <= 1'b0;
            de_count  <= 1'b0;
            grant     <= '0;
            busy      <= 1'b0;
            drop      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            sel       <= sel_nxt;
            sel_inc   <= sel_inc_nxt;
            gap_cnt   <= gap_nxt;
            req_inc_q <= req_inc;
            req_dec_q <= req_dec;
            pend_inc  <= (pend_inc & ~clr_inc) | (req_inc & ~req_inc_q);
            pend_dec  <= (pend_dec & ~clr_dec) | (req_dec & ~req_dec_q);
            count     <= count_nxt;
            de_count  <= de_count_nxt;
            grant     <= grant_nxt;
            busy      <= (state_nxt != S_IDLE);
            drop      <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_counter_cmd_scheduler.sv
// tb_counter_cmd_scheduler: scoreboard bench for the counter command scheduler.
// Expected pulse events are queued as stimulus is driven and retired by a negedge monitor.
// Scenario tasks add inline timing checks on traced output cycles.
`timescale 1ns/1ps
module tb_counter_cmd_scheduler;

    localparam int N   = 2;
    localparam int GAP = 2;

`ifdef COUNTER_SCHED_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [1:0] K_CNT  = 2'd0;
    localparam logic [1:0] K_DEC  = 2'd1;
    localparam logic [1:0] K_DROP = 2'd2;

    typedef struct packed {
        logic [1:0]   kind;
        logic [N-1:0] grant;
    } ev_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req_inc, req_dec;
    logic [3:0]   counter_value;
    logic         count, de_count, busy, drop;
    logic [N-1:0] grant;

    int  errors = 0;
    int  checks = 0;
    ev_t exp_q[$];
    ev_t mon_act, mon_exp;

    logic         tr_count [0:15];
    logic         tr_de    [0:15];
    logic         tr_busy  [0:15];
    logic         tr_drop  [0:15];
    logic [N-1:0] tr_grant [0:15];

    always #5 clk = ~clk;

    counter_cmd_scheduler #(.N(N), .GAP(GAP)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_inc       (req_inc),
        .req_dec       (req_dec),
        .counter_value (counter_value),
        .count         (count),
        .de_count      (de_count),
        .grant         (grant),
        .busy          (busy),
        .drop          (drop)
    );

    function automatic ev_t mk(input logic [1:0] k, input logic [N-1:0] g);
        ev_t e;
        e.kind  = k;
        e.grant = g;
        return e;
    endfunction

    // Monitor: retire one expected event per pulse cycle and watch the output invariants.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ((count & de_count) !== 1'b0) begin
                errors++;
                $display("FAIL pulse_exclusive: count=%b de_count=%b, required not both high", count, de_count);
            end
            checks++;
            if ((grant & (grant - N'(1))) !== '0) begin
                errors++;
                $display("FAIL grant_onehot: got %b, required one-hot or zero", grant);
            end
            if (count || de_count || drop) begin
                mon_act.kind  = count ? K_CNT : (de_count ? K_DEC : K_DROP);
                mon_act.grant = grant;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got kind=%0d grant=%b, required no event", mon_act.kind, mon_act.grant);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        errors++;
                        $display("FAIL event_order: got kind=%0d grant=%b, required kind=%0d grant=%b",
                                 mon_act.kind, mon_act.grant, mon_exp.kind, mon_exp.grant);
                    end
                end
            end else begin
                checks++;
                if (grant !== '0) begin
                    errors++;
                    $display("FAIL grant_idle: got %b with no pulse, required 0", grant);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Sample n consecutive post-edge cycles into the trace arrays.
    task automatic run_trace(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            tr_count[i] = count;
            tr_de[i]    = de_count;
            tr_busy[i]  = busy;
            tr_drop[i]  = drop;
            tr_grant[i] = grant;
        end
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req_inc = '0;
        req_dec = '0;
        idle_cycles(3);
        reset = 1'b0;
        idle_cycles(3);
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        req_inc       = '0;
        req_dec       = '0;
        counter_value = 4'd0;
        idle_cycles(3);
        @(negedge clk);
        checks++; if (count !== 1'b0)    begin errors++; $display("FAIL reset_count: got %b, required 0", count); end
        checks++; if (de_count !== 1'b0) begin errors++; $display("FAIL reset_de_count: got %b, required 0", de_count); end
        checks++; if (grant !== '0)      begin errors++; $display("FAIL reset_grant: got %b, required 0", grant); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (drop !== 1'b0)     begin errors++; $display("FAIL reset_drop: got %b, required 0", drop); end
        step();
        reset = 1'b0;
        run_trace(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tr_busy[i] !== 1'b0) begin errors++; $display("FAIL reset_release_busy[%0d]: got %b, required 0", i, tr_busy[i]); end
        end
    endtask

    task automatic test_single_inc();
        logic exp_c, exp_b;
        do_reset();
        counter_value = 4'd3;
        req_inc = 2'b01;
        exp_q.push_back(mk(K_CNT, 2'b01));
        run_trace(8);
        for (int i = 0; i < 8; i++) begin
            exp_c = (i == 1);
            exp_b = (i >= 1) && (i <= GAP + 1);
            checks++;
            if (tr_count[i] !== exp_c) begin errors++; $display("FAIL single_inc_count[%0d]: got %b, required %b", i, tr_count[i], exp_c); end
            checks++;
            if (tr_busy[i] !== exp_b) begin errors++; $display("FAIL single_inc_busy[%0d]: got %b, required %b", i, tr_busy[i], exp_b); end
        end
        checks++;
        if (tr_grant[1] !== 2'b01) begin errors++; $display("FAIL single_inc_grant: got %b, required 01", tr_grant[1]); end
        req_inc = '0;
        idle_cycles(3);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL single_inc_drain: %0d events outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        do_reset();
        counter_value = 4'd5;
        for (int r = 0; r < 2; r++) begin
            req_inc = 2'b01;
            req_dec = 2'b10;
            exp_q.push_back(mk(K_CNT, 2'b01));
            exp_q.push_back(mk(K_DEC, 2'b10));
            run_trace(10);
            checks++;
            if (tr_count[1] !== 1'b1) begin errors++; $display("FAIL rr%0d_count_time: got %b at cycle 1, required 1", r, tr_count[1]); end
            checks++;
            if (tr_de[GAP + 3] !== 1'b1) begin errors++; $display("FAIL rr%0d_de_count_time: got %b at cycle %0d, required 1", r, tr_de[GAP + 3], GAP + 3); end
            checks++;
            if (tr_grant[GAP + 3] !== 2'b10) begin errors++; $display("FAIL rr%0d_de_grant: got %b, required 10", r, tr_grant[GAP + 3]); end
            req_inc = '0;
            req_dec = '0;
            idle_cycles(2);
        end
        // Serve requester 0 alone, so requester 1 has priority in the next contest.
        req_inc = 2'b01;
        exp_q.push_back(mk(K_CNT, 2'b01));
        idle_cycles(8);
        req_inc = '0;
        idle_cycles(2);
        req_inc = 2'b01;
        req_dec = 2'b10;
        exp_q.push_back(mk(K_DEC, 2'b10));
        exp_q.push_back(mk(K_CNT, 2'b01));
        idle_cycles(14);
        req_inc = '0;
        req_dec = '0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rr_drain: %0d events outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_saturation();
        do_reset();
        counter_value = 4'd15;
        req_inc = 2'b10;
        exp_q.push_back(mk(WRAP ? K_CNT : K_DROP, 2'b10));
        run_trace(6);
        checks++;
        if (tr_drop[1] !== !WRAP) begin errors++; $display("FAIL sat_inc_drop: got %b, required %b", tr_drop[1], !WRAP); end
        checks++;
        if (tr_count[1] !== WRAP) begin errors++; $display("FAIL sat_inc_count: got %b, required %b", tr_count[1], WRAP); end
        checks++;
        if (tr_grant[1] !== 2'b10) begin errors++; $display("FAIL sat_inc_grant: got %b, required 10", tr_grant[1]); end
        checks++;
        if (tr_busy[2] !== WRAP) begin errors++; $display("FAIL sat_inc_idle_return: busy %b, required %b", tr_busy[2], WRAP); end
        req_inc = '0;
        idle_cycles(2);

        counter_value = 4'd0;
        req_dec = 2'b01;
        exp_q.push_back(mk(WRAP ? K_DEC : K_DROP, 2'b01));
        run_trace(6);
        checks++;
        if (tr_drop[1] !== !WRAP) begin errors++; $display("FAIL sat_dec_drop: got %b, required %b", tr_drop[1], !WRAP); end
        checks++;
        if (tr_de[1] !== WRAP) begin errors++; $display("FAIL sat_dec_de_count: got %b, required %b", tr_de[1], WRAP); end
        req_dec = '0;
        idle_cycles(2);

        // The opposite direction at each limit is always legal.
        counter_value = 4'd15;
        req_dec = 2'b10;
        exp_q.push_back(mk(K_DEC, 2'b10));
        idle_cycles(7);
        req_dec = '0;
        idle_cycles(2);
        counter_value = 4'd0;
        req_inc = 2'b01;
        exp_q.push_back(mk(K_CNT, 2'b01));
        idle_cycles(7);
        req_inc = '0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sat_drain: %0d events outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_conflict();
        do_reset();
        counter_value = 4'd5;
        req_inc = 2'b01;
        req_dec = 2'b01;
        run_trace(8);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tr_busy[i] !== 1'b0) begin errors++; $display("FAIL conflict_busy[%0d]: got %b, required 0", i, tr_busy[i]); end
        end
        req_inc = '0;
        req_dec = '0;
        idle_cycles(2);
        // The cancelled pick moved the pointer to requester 1.
        req_inc = 2'b11;
        exp_q.push_back(mk(K_CNT, 2'b10));
        exp_q.push_back(mk(K_CNT, 2'b01));
        idle_cycles(14);
        req_inc = '0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL conflict_drain: %0d events outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_held_merge();
        reset   = 1'b1;
        req_inc = 2'b01;
        req_dec = '0;
        counter_value = 4'd5;
        idle_cycles(3);
        reset = 1'b0;
        exp_q.delete();
        run_trace(8);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tr_busy[i] !== 1'b0) begin errors++; $display("FAIL held_busy[%0d]: got %b, required 0", i, tr_busy[i]); end
        end
        req_inc = '0;
        idle_cycles(2);
        // Requester 1 occupies the scheduler while requester 0 rises twice.
        req_inc = 2'b10;
        exp_q.push_back(mk(K_CNT, 2'b10));
        exp_q.push_back(mk(K_CNT, 2'b01));
        step();
        req_inc = 2'b11;
        step();
        req_inc = 2'b10;
        step();
        req_inc = 2'b11;
        idle_cycles(14);
        req_inc = '0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL merge_drain: %0d events outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_issue_edge();
        do_reset();
        counter_value = 4'd7;
        req_inc = 2'b01;
        exp_q.push_back(mk(K_CNT, 2'b01));
        exp_q.push_back(mk(K_CNT, 2'b01));
        step();
        req_inc = 2'b00;
        step();
        req_inc = 2'b01;
        idle_cycles(14);
        req_inc = '0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL issue_edge_drain: %0d events outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_wait();
        do_reset();
        counter_value = 4'd5;
        req_inc = 2'b01;
        req_dec = 2'b10;
        exp_q.push_back(mk(K_CNT, 2'b01));
        idle_cycles(3);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstwait_busy: got %b, required 0", busy); end
        checks++; if (count !== 1'b0)    begin errors++; $display("FAIL rstwait_count: got %b, required 0", count); end
        checks++; if (de_count !== 1'b0) begin errors++; $display("FAIL rstwait_de_count: got %b, required 0", de_count); end
        checks++; if (grant !== '0)      begin errors++; $display("FAIL rstwait_grant: got %b, required 0", grant); end
        checks++; if (drop !== 1'b0)     begin errors++; $display("FAIL rstwait_drop: got %b, required 0", drop); end
        step();
        reset = 1'b0;
        run_trace(12);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (tr_busy[i] !== 1'b0) begin errors++; $display("FAIL rstwait_after_busy[%0d]: got %b, required 0", i, tr_busy[i]); end
        end
        req_inc = '0;
        req_dec = '0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rstwait_drain: %0d events outstanding, required 0", exp_q.size()); end
    endtask

    initial begin
        reset         = 1'b1;
        req_inc       = '0;
        req_dec       = '0;
        counter_value = 4'd0;
        test_reset();
        test_single_inc();
        test_round_robin();
        test_saturation();
        test_conflict();
        test_held_merge();
        test_issue_edge();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
